// File: rtl/lc3_alu_exec.sv
// LC-3 operate-instruction execute/writeback unit (ADD, AND, NOT) sitting in
// front of the register file; one instruction per four-cycle IDLE/READ/EXEC/WB pass.
module lc3_alu_exec #(
    parameter logic [2:0] RESET_CC = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_valid,
    output logic        ir_ready,
    input  logic [15:0] ir,
    input  logic [15:0] Ra,
    input  logic [15:0] Rb,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic [15:0] b,
    output logic        regWE,
    output logic [2:0]  nzp,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    state_t      state;
    logic [15:0] irReg;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] immExt;
    logic [15:0] operand2;
    logic [15:0] aluOut;

    function automatic logic isLegal(input logic [15:0] word);
        case (word[15:12])
            OP_ADD, OP_AND: return 1'b1;
            OP_NOT:         return word[5:0] == 6'b111111;
            default:        return 1'b0;
        endcase
    endfunction

    // Source selects come straight from the latched IR, so they hold until the next accept.
    assign SR1 = irReg[8:6];
    assign SR2 = irReg[2:0];

    always_comb begin
        immExt   = {{11{irReg[4]}}, irReg[4:0]};
        operand2 = irReg[5] ? immExt : opB;
        case (irReg[15:12])
            OP_ADD:  aluOut = opA + operand2;
            OP_AND:  aluOut = opA & operand2;
            default: aluOut = ~opA;
        endcase
    end

    // b doubles as the result register; nzp is derived from it at the WB edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ir_ready <= 1'b1;
            irReg    <= '0;
            opA      <= '0;
            opB      <= '0;
            DR       <= '0;
            b        <= '0;
            regWE    <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            nzp      <= RESET_CC;
        end else begin
            case (state)
                IDLE: begin
                    if (ir_valid) begin
                        irReg    <= ir;
                        ir_ready <= 1'b0;
                        illegal  <= !isLegal(ir);
                        state    <= READ;
                    end
                end
                READ: begin
                    opA     <= Ra;
                    opB     <= Rb;
                    illegal <= 1'b0;
                    if (isLegal(irReg)) begin
                        state <= EXEC;
                    end else begin
                        ir_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                EXEC: begin
                    b     <= aluOut;
                    DR    <= irReg[11:9];
                    regWE <= 1'b1;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    regWE    <= 1'b0;
                    done     <= 1'b0;
                    ir_ready <= 1'b1;
                    nzp      <= {b[15], b == 16'h0000, !b[15] && (b != 16'h0000)};
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_alu_exec.sv
// Randomized self-checking bench for lc3_alu_exec with a behavioural register
// file around the DUT and an arithmetic reference model of the ISA rules.
module tb_lc3_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir;
    logic [15:0] Ra;
    logic [15:0] Rb;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic [2:0]  DR;
    logic [15:0] b;
    logic        regWE;
    logic [2:0]  nzp;
    logic        done;
    logic        illegal;

    logic [15:0] rf [8];
    logic        pokeEn;
    logic [2:0]  pokeAddr;
    logic [15:0] pokeData;

    logic [15:0] refRegs [8];
    logic [2:0]  refNzp;

    int checkCount = 0;
    int passCount  = 0;

    lc3_alu_exec #(.RESET_CC(3'b010)) dut (
        .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .Ra(Ra), .Rb(Rb), .SR1(SR1), .SR2(SR2), .DR(DR), .b(b), .regWE(regWE),
        .nzp(nzp), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign Ra = rf[SR1];
    assign Rb = rf[SR2];

    // Register file: DUT writeback, or a bench preload while the DUT is idle.
    always @(posedge clk) begin
        if (regWE === 1'b1) rf[DR] <= b;
        else if (pokeEn) rf[pokeAddr] <= pokeData;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
    endtask

    function automatic void predict(input logic [15:0] w, output logic legal, output logic [15:0] res);
        int a, bv, imm;
        a   = int'(refRegs[w[8:6]]);
        imm = int'(w[4:0]);
        if (imm > 15) imm = imm - 32;
        bv  = w[5] ? imm : int'(refRegs[w[2:0]]);
        legal = 1'b0;
        res   = 16'h0000;
        case (w[15:12])
            4'd1: begin legal = 1'b1; res = 16'((a + bv) & 32'hFFFF); end
            4'd5: begin legal = 1'b1; res = 16'(a & (bv & 32'hFFFF)); end
            4'd9: begin legal = (w[5:0] == 6'h3F); res = 16'(65535 - a); end
            default: ;
        endcase
    endfunction

    function automatic logic [2:0] expectNzp(input logic [15:0] res);
        if (res == 16'h0000) return 3'b010;
        else if (res >= 16'h8000) return 3'b100;
        else return 3'b001;
    endfunction

    task automatic pokeReg(input logic [2:0] addr, input logic [15:0] data);
        pokeEn = 1'b1; pokeAddr = addr; pokeData = data;
        @(negedge clk);
        pokeEn = 1'b0;
        refRegs[addr] = data;
    endtask

    task automatic waitReady();
        int n = 0;
        while (ir_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("ready_timeout", 16'(ir_ready), 16'd1);
    endtask

    // One instruction from accept to retirement, checked cycle by cycle.
    task automatic applyStimulus(input logic [15:0] word);
        logic        legal;
        logic [15:0] res;
        logic [2:0]  dr;
        waitReady();
        predict(word, legal, res);
        dr = word[11:9];
        ir = word; ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0;
        checkOutput("read_illegal", 16'(illegal), 16'(!legal));
        checkOutput("read_ready", 16'(ir_ready), 16'd0);
        checkOutput("read_regwe", 16'(regWE), 16'd0);
        checkOutput("read_done", 16'(done), 16'd0);
        @(negedge clk);
        if (!legal) begin
            checkOutput("ill_ready", 16'(ir_ready), 16'd1);
            checkOutput("ill_pulse_end", 16'(illegal), 16'd0);
            checkOutput("ill_regwe", 16'(regWE), 16'd0);
            checkOutput("ill_nzp", 16'(nzp), 16'(refNzp));
        end else begin
            checkOutput("exec_regwe", 16'(regWE), 16'd0);
            checkOutput("exec_done", 16'(done), 16'd0);
            @(negedge clk);
            checkOutput("wb_regwe", 16'(regWE), 16'd1);
            checkOutput("wb_done", 16'(done), 16'd1);
            checkOutput("wb_illegal", 16'(illegal), 16'd0);
            checkOutput("wb_dr", 16'(DR), 16'(dr));
            checkOutput("wb_b", b, res);
            @(negedge clk);
            refRegs[dr] = res;
            refNzp = expectNzp(res);
            checkOutput("post_nzp", 16'(nzp), 16'(refNzp));
            checkOutput("post_ready", 16'(ir_ready), 16'd1);
            checkOutput("post_regwe", 16'(regWE), 16'd0);
            checkOutput("post_rf", rf[dr], res);
        end
    endtask

    // ir_valid held high: each word must be taken exactly once, four cycles apart.
    task automatic runPipeline();
        localparam int N = 6;
        logic [15:0] words [N];
        logic [15:0] expB [$];
        logic [2:0]  expDR [$];
        logic        legal;
        logic [15:0] res;
        logic        acc;
        int cyc, lastAcc, k, doneCount;
        for (int i = 0; i < N; i++)
            words[i] = {4'b0001, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 6'($urandom)};
        cyc = 0; lastAcc = -1; k = 0; doneCount = 0;
        waitReady();
        ir = words[0]; ir_valid = 1'b1;
        while ((k < N || expB.size() > 0) && cyc < 200) begin
            acc = 1'b0;
            if (done === 1'b1) begin
                if (expB.size() == 0) begin
                    checkOutput("pipe_extra_done", 16'd1, 16'd0);
                end else begin
                    checkOutput("pipe_b", b, expB[0]);
                    checkOutput("pipe_dr", 16'(DR), 16'(expDR[0]));
                    refRegs[expDR[0]] = expB[0];
                    refNzp = expectNzp(expB[0]);
                    void'(expB.pop_front());
                    void'(expDR.pop_front());
                end
                doneCount++;
            end
            if (ir_ready === 1'b1 && ir_valid) begin
                predict(ir, legal, res);
                expB.push_back(res);
                expDR.push_back(ir[11:9]);
                if (lastAcc >= 0) checkOutput("pipe_accept_gap", 16'(cyc - lastAcc), 16'd4);
                lastAcc = cyc;
                k++;
                acc = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (k < N) ir = words[k];
                else ir_valid = 1'b0;
            end
        end
        ir_valid = 1'b0;
        checkOutput("pipe_in_time", 16'(cyc < 200), 16'd1);
        checkOutput("pipe_done_count", 16'(doneCount), 16'(N));
        checkOutput("pipe_nzp", 16'(nzp), 16'(refNzp));
    endtask

    task automatic resetDuringExec();
        pokeReg(3'd1, 16'd5);
        pokeReg(3'd2, 16'd7);
        applyStimulus(16'h1642);
        checkOutput("pre_reset_nzp", 16'(nzp), 16'(3'b001));
        waitReady();
        ir = 16'h1642; ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        refNzp = 3'b010;
        checkOutput("rst_exec_regwe", 16'(regWE), 16'd0);
        checkOutput("rst_exec_done", 16'(done), 16'd0);
        checkOutput("rst_exec_ready", 16'(ir_ready), 16'd1);
        checkOutput("rst_exec_nzp", 16'(nzp), 16'(3'b010));
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_after_regwe", 16'(regWE), 16'd0);
        end
    endtask

    initial begin
        reset = 1'b1; ir_valid = 1'b0; ir = 16'h0000;
        pokeEn = 1'b0; pokeAddr = 3'd0; pokeData = 16'h0000;
        refNzp = 3'b010;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            checkOutput("idle_ready", 16'(ir_ready), 16'd1);
            checkOutput("idle_regwe", 16'(regWE), 16'd0);
            checkOutput("idle_done", 16'(done), 16'd0);
            checkOutput("idle_illegal", 16'(illegal), 16'd0);
            checkOutput("idle_nzp", 16'(nzp), 16'(3'b010));
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) pokeReg(3'(i), 16'(i * 3 + 1));

        pokeReg(3'd1, 16'd5);
        pokeReg(3'd2, 16'd7);
        applyStimulus(16'h1642);
        checkOutput("add_r3", rf[3], 16'h000C);
        applyStimulus(16'h187A);
        checkOutput("add_imm_wrap", rf[4], 16'hFFFF);
        applyStimulus(16'h5060);
        checkOutput("and_zero_nzp", 16'(nzp), 16'(3'b010));
        pokeReg(3'd2, 16'h00FF);
        applyStimulus(16'h9ABF);
        checkOutput("not_r5", rf[5], 16'hFF00);
        applyStimulus(16'h0000);
        applyStimulus(16'h9A80);
        checkOutput("illegal_nzp_kept", 16'(nzp), 16'(3'b100));

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [5:0]  low;
            if ($urandom_range(0, 3) == 0) pokeReg(3'($urandom_range(0, 7)), 16'($urandom));
            low = 6'($urandom);
            case ($urandom_range(0, 3))
                0: op = 4'b0001;
                1: op = 4'b0101;
                2: begin op = 4'b1001; if ($urandom_range(0, 3) != 0) low = 6'h3F; end
                default: op = 4'($urandom_range(0, 15));
            endcase
            applyStimulus({op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), low});
        end

        runPipeline();
        resetDuringExec();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lc3_alu_exec.md
# lc3_alu_exec

Multi-cycle LC-3 execute/writeback unit that sits directly in front of the register file. It accepts one operate instruction (ADD, AND, NOT) per handshake and drives SR1/SR2 to read operands from the register file's Ra/Rb ports. It computes the result, writes it back via b/DR/regWE, and maintains the NZP condition-code register.

## Interface
- RESET_CC, 3'b010: NZP value loaded on reset (Z set).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- ir_valid  in  1  instruction word on ir is valid.
- ir_ready  out  1  unit can accept an instruction; high only in IDLE.
- ir  in  16  LC-3 instruction word.
- Ra  in  16  register file read data for SR1 (combinational read).
- Rb  in  16  register file read data for SR2 (combinational read).
- SR1  out  3  source register 1 select to register file.
- SR2  out  3  source register 2 select to register file.
- DR  out  3  destination register select to register file.
- b  out  16  writeback data to register file.
- regWE  out  1  register file write enable; one-cycle pulse.
- nzp  out  3  condition codes {N,Z,P}; always one-hot.
- done  out  1  one-cycle pulse; instruction retired with writeback.
- illegal  out  1  one-cycle pulse; instruction rejected, no writeback.

## Operation
- Handshake: instruction accepted at a rising edge where ir_valid && ir_ready. ir is latched into an internal IR at that edge. ir_valid while busy is ignored; the word is not consumed.
- Field decode from latched IR:
  - opcode = IR[15:12]; DR = IR[11:9]; SR1 = IR[8:6]; SR2 = IR[2:0].
  - imm flag = IR[5]; imm5 = IR[4:0] sign-extended to 16 bits.
- ADD (0001): result = Ra + (imm ? sext(imm5) : Rb).
- AND (0101): result = Ra & (imm ? sext(imm5) : Rb).
- NOT (1001): result = ~Ra. Requires IR[5:0] = 6'b111111; otherwise illegal.
- Any other opcode: illegal.
- Arithmetic is 16-bit modulo 2^16. No carry or overflow output.
- NZP update occurs at the WB edge and is skipped for illegal instructions:
  - N = result[15];
  - Z = (result == 0);
  - P = !N && !Z.
- State machine:
  - IDLE: ir_ready=1. Go to READ on accept; otherwise stay.
  - READ: SR1/SR2 driven from IR. Ra/Rb are latched into operand registers at the end of the cycle. Go to EXEC if legal. If illegal, assert illegal for this cycle and go to IDLE.
  - EXEC: result computed from the latched operands into a result register. Go to WB.
  - WB: regWE=1, b=result, DR=IR[11:9], done=1. nzp loads at the end of the cycle. Go to IDLE.
- Outside WB: regWE=0. SR1, SR2, DR and b hold their last driven values.
- Reset values: state IDLE, ir_ready=1, SR1=SR2=DR=0, b=0, regWE=0, done=0, illegal=0, nzp=RESET_CC, IR and operand registers 0.
- Reset in any state, including WB: state returns to IDLE, and regWE=0 in the cycle after the reset edge.
  - Reset asserted during WB has priority; nzp takes RESET_CC.
  - The register file shares the same reset, so the write is moot.

## Timing
- Legal instruction accepted at edge E0:
  - READ during cycle E0→E1;
  - EXEC during E1→E2;
  - WB during E2→E3, with regWE and done high;
  - register and nzp updated at E3;
  - ir_ready high again in the cycle after E3.
- Throughput: one instruction per 4 cycles, as the next accept is at the earliest at E4.
- Illegal instruction: illegal high in cycle E0→E1; ir_ready high from E1.
- No read-after-write hazard. The next READ starts at E4 or later, after the write edge E3.
- done and illegal are never high in the same cycle. Each is high for exactly one cycle per instruction.

## Test plan
- Reset then idle 5 cycles -> ir_ready=1, regWE=0, done=0, illegal=0, nzp=3'b010 throughout.
- R1=5, R2=7 preset; ir=0x1642 (ADD R3,R1,R2) -> regWE high exactly 3 cycles after accept with DR=3, b=0x000C; nzp=3'b001 afterward; register file R3=12.
- R1=5; ir=0x187A (ADD R4,R1,#-6) -> b=0xFFFF (wrap), DR=4, nzp=3'b100.
- ir=0x5060 (AND R0,R1,#0) -> b=0x0000, DR=0, nzp=3'b010. Then R2=0x00FF and ir=0x9ABF (NOT R5,R2) -> b=0xFF00, DR=5, nzp=3'b100.
- ir=0x0000 (BR opcode), then ir=0x9A80 (NOT with IR[5:0]≠111111):
  - each -> illegal pulse in the cycle after accept;
  - no regWE, no done, nzp unchanged.
- Two more cases:
  - ir_valid held high continuously with ADD words -> one accept every 4 cycles; no words lost or duplicated.
  - reset asserted during EXEC -> no regWE pulse, ir_ready=1 and nzp=3'b010 the next cycle.
